// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM states and helpers for the MEM stage and its lane aligner.
package mem_access_pkg;

   localparam logic [7:0] EXE_ADD_OP = 8'h20;
   localparam logic [7:0] EXE_LB_OP  = 8'he0;
   localparam logic [7:0] EXE_LH_OP  = 8'he1;
   localparam logic [7:0] EXE_LW_OP  = 8'he3;
   localparam logic [7:0] EXE_LBU_OP = 8'he4;
   localparam logic [7:0] EXE_LHU_OP = 8'he5;
   localparam logic [7:0] EXE_SB_OP  = 8'he8;
   localparam logic [7:0] EXE_SH_OP  = 8'he9;
   localparam logic [7:0] EXE_SW_OP  = 8'heb;

   typedef enum logic [1:0] {MA_IDLE, MA_REQ1, MA_REQ2, MA_DONE} ma_state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;

   typedef struct packed {
      logic      is_mem;
      logic      is_store;
      logic      is_unsigned;
      mem_size_t size;
   } mem_op_t;

   function automatic logic [3:0] word_byte_en(input mem_size_t size);
      case (size)
         SZ_BYTE: word_byte_en = 4'b0001;
         SZ_HALF: word_byte_en = 4'b0011;
         default: word_byte_en = 4'b1111;
      endcase
   endfunction

   function automatic mem_op_t decode_op(input logic [7:0] aluop);
      mem_op_t op;
      op.is_mem      = 1'b1;
      op.is_store    = 1'b0;
      op.is_unsigned = 1'b0;
      op.size        = SZ_BYTE;
      case (aluop)
         EXE_LB_OP:  op.size = SZ_BYTE;
         EXE_LH_OP:  op.size = SZ_HALF;
         EXE_LW_OP:  op.size = SZ_WORD;
         EXE_LBU_OP: op.is_unsigned = 1'b1;
         EXE_LHU_OP: begin op.size = SZ_HALF; op.is_unsigned = 1'b1; end
         EXE_SB_OP:  op.is_store = 1'b1;
         EXE_SH_OP:  begin op.size = SZ_HALF; op.is_store = 1'b1; end
         EXE_SW_OP:  begin op.size = SZ_WORD; op.is_store = 1'b1; end
         default:    op.is_mem = 1'b0;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Combinational lane steering: byte enables and shifted store data per transaction part,
// plus load byte merging across two words and final sign/zero extension.
module mem_access_lane_align
   import mem_access_pkg::*;
(
   input  mem_size_t   size,
   input  logic        is_unsigned,
   input  logic [1:0]  offset,
   input  logic        bus_part,
   input  logic [31:0] store_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic        load_part,
   input  logic [31:0] rdata,
   input  logic [31:0] load_raw,
   output logic [31:0] load_merged,
   output logic [31:0] load_data
);

   logic [7:0]  mask8;
   logic [4:0]  sh_up;
   logic [5:0]  sh_dn;
   logic [31:0] st_sized;

   // Upper nibble of the shifted size mask is what spills into the next word.
   always_comb begin
      mask8 = {4'b0000, word_byte_en(size)} << offset;
      sh_up = {offset, 3'b000};
      sh_dn = 6'd32 - {1'b0, sh_up};
      case (size)
         SZ_BYTE: st_sized = {24'd0, store_data[7:0]};
         SZ_HALF: st_sized = {16'd0, store_data[15:0]};
         default: st_sized = store_data;
      endcase
      if (bus_part) begin
         be    = mask8[7:4];
         wdata = st_sized >> sh_dn;
      end else begin
         be    = mask8[3:0];
         wdata = st_sized << sh_up;
      end
      if (load_part)
         load_merged = load_raw | (rdata << sh_dn);
      else
         load_merged = rdata >> sh_up;
      case (size)
         SZ_BYTE: load_data = is_unsigned ? {24'd0, load_raw[7:0]}
                                          : {{24{load_raw[7]}}, load_raw[7:0]};
         SZ_HALF: load_data = is_unsigned ? {16'd0, load_raw[15:0]}
                                          : {{16{load_raw[15]}}, load_raw[15:0]};
         default: load_data = load_raw;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: runs loads/stores over a req/ack port, splitting word-crossing
// accesses into two transactions and stalling the pipeline while the bus is busy.
module mem_access
   import mem_access_pkg::*;
#(
   parameter bit MISALIGN_SPLIT = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stallreq_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   ma_state_t   state;
   mem_op_t     op_d, op_q, cur_op;
   logic [1:0]  off_d, off_q, cur_off;
   logic        cross_d, cross_q;
   logic [31:0] data_q, cur_data, load_raw;
   logic        bus_part, load_part;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, load_merged, load_data;

   // Without splitting, the offset is forced onto the access size's natural alignment.
   always_comb begin
      op_d  = decode_op(aluop_i);
      off_d = mem_addr_i[1:0];
      if (!MISALIGN_SPLIT) begin
         case (op_d.size)
            SZ_HALF: off_d[0] = 1'b0;
            SZ_WORD: off_d = 2'b00;
            default: ;
         endcase
      end
      cross_d = MISALIGN_SPLIT && ((op_d.size == SZ_HALF && off_d == 2'd3) ||
                                   (op_d.size == SZ_WORD && off_d != 2'd0));
   end

   // In IDLE the aligner sees the live op for part 1; afterwards the latched op for part 2.
   always_comb begin
      if (state == MA_IDLE) begin
         cur_op   = op_d;
         cur_off  = off_d;
         cur_data = reg2_i;
      end else begin
         cur_op   = op_q;
         cur_off  = off_q;
         cur_data = data_q;
      end
      bus_part  = (state != MA_IDLE);
      load_part = (state == MA_REQ2);
   end

   mem_access_lane_align u_lane_align (
      .size        (cur_op.size),
      .is_unsigned (cur_op.is_unsigned),
      .offset      (cur_off),
      .bus_part    (bus_part),
      .store_data  (cur_data),
      .be          (lane_be),
      .wdata       (lane_wdata),
      .load_part   (load_part),
      .rdata       (mem_rdata_i),
      .load_raw    (load_raw),
      .load_merged (load_merged),
      .load_data   (load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= MA_IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'd0;
         mem_be_o    <= 4'd0;
         mem_wdata_o <= 32'd0;
         load_raw    <= 32'd0;
         op_q        <= '0;
         off_q       <= 2'd0;
         cross_q     <= 1'b0;
         data_q      <= 32'd0;
      end else begin
         case (state)
            MA_IDLE: begin
               if (op_d.is_mem) begin
                  state       <= MA_REQ1;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= op_d.is_store;
                  mem_addr_o  <= {mem_addr_i[31:2], 2'b00};
                  mem_be_o    <= lane_be;
                  mem_wdata_o <= lane_wdata;
                  op_q        <= op_d;
                  off_q       <= off_d;
                  cross_q     <= cross_d;
                  data_q      <= reg2_i;
               end
            end
            MA_REQ1: begin
               if (mem_ack_i) begin
                  load_raw <= load_merged;
                  if (cross_q) begin
                     state       <= MA_REQ2;
                     mem_addr_o  <= mem_addr_o + 32'd4;
                     mem_be_o    <= lane_be;
                     mem_wdata_o <= lane_wdata;
                  end else begin
                     state     <= MA_DONE;
                     mem_req_o <= 1'b0;
                     mem_we_o  <= 1'b0;
                  end
               end
            end
            MA_REQ2: begin
               if (mem_ack_i) begin
                  load_raw  <= load_merged;
                  state     <= MA_DONE;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
               end
            end
            default: state <= MA_IDLE;
         endcase
      end
   end

   // Writeback is suppressed while stalled; DONE presents the assembled load result.
   always_comb begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      stallreq_o = 1'b0;
      case (state)
         MA_IDLE: begin
            if (op_d.is_mem && !rst) begin
               stallreq_o = 1'b1;
               wreg_o     = 1'b0;
            end
         end
         MA_REQ1, MA_REQ2: begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
         end
         default: begin
            if (op_q.is_store) begin
               wreg_o = 1'b0;
            end else begin
               wdata_o = load_data;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, aligned and split loads/stores, reset mid-access.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk, rst;
   logic [7:0]  aluop_i;
   logic [31:0] mem_addr_i, reg2_i, wdata_i, mem_rdata_i;
   logic [4:0]  wd_i;
   logic        wreg_i, mem_ack_i;
   logic [4:0]  wd_o;
   logic        wreg_o, stallreq_o, mem_req_o, mem_we_o;
   logic [31:0] wdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access dut (
      .clk         (clk),
      .rst         (rst),
      .aluop_i     (aluop_i),
      .mem_addr_i  (mem_addr_i),
      .reg2_i      (reg2_i),
      .wd_i        (wd_i),
      .wreg_i      (wreg_i),
      .wdata_i     (wdata_i),
      .wd_o        (wd_o),
      .wreg_o      (wreg_o),
      .wdata_o     (wdata_o),
      .stallreq_o  (stallreq_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_be_o    (mem_be_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] st,
                        input logic [4:0] wd, input logic wr);
      aluop_i    = op;
      mem_addr_i = addr;
      reg2_i     = st;
      wd_i       = wd;
      wreg_i     = wr;
      wdata_i    = 32'h0000_5555;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_ack_i = 1'b0;
      mem_rdata_i = 32'd0;
      drive(EXE_ADD_OP, 32'd0, 32'd0, 5'd0, 1'b0);
      #3;
      n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req_o); end
      n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b expected 0", mem_we_o); end
      n_checks++; if (mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_addr_wdata: got %h/%h expected 0/0", mem_addr_o, mem_wdata_o); end
      n_checks++; if (mem_be_o !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_be: got %h expected 0", mem_be_o); end
      n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", stallreq_o); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_passthrough();
      drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd5, 1'b1);
      wdata_i = 32'h0000_1234;
      mem_ack_i = 1'b1;
      #1;
      n_checks++; if (wdata_o !== 32'h1234 || wd_o !== 5'd5 || wreg_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pass_outputs: got %h/%0d/%b expected 00001234/5/1", wdata_o, wd_o, wreg_o); end
      n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_stall: got %b expected 0", stallreq_o); end
      tick();
      n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_noreq: got %b expected 0", mem_req_o); end
      mem_ack_i = 1'b0;
   endtask

   task automatic test_lw_aligned();
      drive(EXE_LW_OP, 32'h100, 32'h0, 5'd7, 1'b1);
      #1;
      n_checks++; if (stallreq_o !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_idle_stall: got %b expected 1", stallreq_o); end
      tick();
      n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_req_we: got %b/%b expected 1/0", mem_req_o, mem_we_o); end
      n_checks++; if (mem_addr_o !== 32'h100 || mem_be_o !== 4'hF) begin n_fail++; $display("[TB] FAIL lw_addr_be: got %h/%h expected 00000100/f", mem_addr_o, mem_be_o); end
      n_checks++; if (stallreq_o !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_req_stall: got %b expected 1", stallreq_o); end
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'hDEADBEEF;
      tick();
      mem_ack_i = 1'b0;
      mem_rdata_i = 32'h0;
      #1;
      n_checks++; if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_done_req_stall: got %b/%b expected 0/0", mem_req_o, stallreq_o); end
      n_checks++; if (wdata_o !== 32'hDEADBEEF || wd_o !== 5'd7 || wreg_o !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_done_data: got %h/%0d/%b expected deadbeef/7/1", wdata_o, wd_o, wreg_o); end
      tick();
      drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd0, 1'b0);
      #1;
      n_checks++; if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_back_idle: got %b/%b expected 0/0", mem_req_o, stallreq_o); end
   endtask

   task automatic test_byte_loads();
      logic [7:0]  ops [2];
      logic [31:0] exp [2];
      ops[0] = EXE_LB_OP;  exp[0] = 32'hFFFFFF80;
      ops[1] = EXE_LBU_OP; exp[1] = 32'h00000080;
      for (int i = 0; i < 2; i++) begin
         drive(ops[i], 32'h103, 32'h0, 5'd3, 1'b1);
         tick();
         n_checks++; if (mem_be_o !== 4'h8 || mem_addr_o !== 32'h100) begin n_fail++; $display("[TB] FAIL byte_be_addr[%0d]: got %h/%h expected 8/00000100", i, mem_be_o, mem_addr_o); end
         mem_ack_i = 1'b1;
         mem_rdata_i = 32'h80FFFFFF;
         tick();
         mem_ack_i = 1'b0;
         #1;
         n_checks++; if (wdata_o !== exp[i]) begin n_fail++; $display("[TB] FAIL byte_data[%0d]: got %h expected %h", i, wdata_o, exp[i]); end
         tick();
         drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd0, 1'b0);
      end
   endtask

   task automatic test_sh();
      drive(EXE_SH_OP, 32'h102, 32'h0000ABCD, 5'd9, 1'b1);
      tick();
      n_checks++; if (mem_be_o !== 4'hC || mem_wdata_o !== 32'hABCD0000) begin n_fail++; $display("[TB] FAIL sh_be_data: got %h/%h expected c/abcd0000", mem_be_o, mem_wdata_o); end
      n_checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h100) begin n_fail++; $display("[TB] FAIL sh_we_addr: got %b/%h expected 1/00000100", mem_we_o, mem_addr_o); end
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      #1;
      n_checks++; if (wreg_o !== 1'b0 || stallreq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL sh_done_wreg_stall: got %b/%b expected 0/0", wreg_o, stallreq_o); end
      tick();
      drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd0, 1'b0);
   endtask

   task automatic test_sw_split();
      drive(EXE_SW_OP, 32'h101, 32'h11223344, 5'd4, 1'b1);
      tick();
      n_checks++; if (mem_addr_o !== 32'h100 || mem_be_o !== 4'hE || mem_wdata_o !== 32'h22334400) begin n_fail++; $display("[TB] FAIL sw_part1: got %h/%h/%h expected 00000100/e/22334400", mem_addr_o, mem_be_o, mem_wdata_o); end
      mem_ack_i = 1'b1;
      tick();
      n_checks++; if (mem_req_o !== 1'b1 || stallreq_o !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_part2_req: got %b/%b expected 1/1", mem_req_o, stallreq_o); end
      n_checks++; if (mem_addr_o !== 32'h104 || mem_be_o !== 4'h1 || mem_wdata_o !== 32'h00000011) begin n_fail++; $display("[TB] FAIL sw_part2: got %h/%h/%h expected 00000104/1/00000011", mem_addr_o, mem_be_o, mem_wdata_o); end
      tick();
      mem_ack_i = 1'b0;
      #1;
      n_checks++; if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0 || wreg_o !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_done: got %b/%b/%b expected 0/0/0", mem_req_o, stallreq_o, wreg_o); end
      tick();
      drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd0, 1'b0);
   endtask

   task automatic test_split_loads();
      logic [7:0]  ops [2];
      logic [31:0] addrs [2], rd1 [2], rd2 [2], exp [2];
      ops[0] = EXE_LW_OP; addrs[0] = 32'h102; rd1[0] = 32'hAABBCCDD; rd2[0] = 32'h11223344; exp[0] = 32'h3344AABB;
      ops[1] = EXE_LH_OP; addrs[1] = 32'h103; rd1[1] = 32'hAB000000; rd2[1] = 32'h000000CD; exp[1] = 32'hFFFFCDAB;
      for (int i = 0; i < 2; i++) begin
         drive(ops[i], addrs[i], 32'h0, 5'd11, 1'b1);
         tick();
         mem_ack_i = 1'b1;
         mem_rdata_i = rd1[i];
         tick();
         n_checks++; if (mem_addr_o !== 32'h104 || mem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL split_part2[%0d]: got %h/%b expected 00000104/1", i, mem_addr_o, mem_req_o); end
         mem_rdata_i = rd2[i];
         tick();
         mem_ack_i = 1'b0;
         #1;
         n_checks++; if (wdata_o !== exp[i] || wreg_o !== 1'b1) begin n_fail++; $display("[TB] FAIL split_data[%0d]: got %h/%b expected %h/1", i, wdata_o, wreg_o, exp[i]); end
         tick();
         drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd0, 1'b0);
      end
   endtask

   task automatic test_delayed_ack_reset();
      drive(EXE_LW_OP, 32'h102, 32'h0, 5'd2, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_be_o !== 4'hC || stallreq_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wait_stable[%0d]: got %b/%h/%h/%b expected 1/00000100/c/1", i, mem_req_o, mem_addr_o, mem_be_o, stallreq_o); end
         tick();
      end
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'h12345678;
      tick();
      mem_ack_i = 1'b0;
      #1;
      n_checks++; if (mem_addr_o !== 32'h104 || mem_be_o !== 4'h3) begin n_fail++; $display("[TB] FAIL wait_part2: got %h/%h expected 00000104/3", mem_addr_o, mem_be_o); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (mem_req_o !== 1'b0 || mem_be_o !== 4'h0 || mem_addr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_bus: got %b/%h/%h expected 0/0/00000000", mem_req_o, mem_be_o, mem_addr_o); end
      n_checks++; if (dut.state !== MA_IDLE || stallreq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_state_stall: got %0d/%b expected 0/0", dut.state, stallreq_o); end
      drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_after: got %b expected 0", mem_req_o); end
   endtask

   initial begin
      $display("[TB] mem_access directed test start");
      test_reset();
      test_passthrough();
      test_lw_aligned();
      test_byte_loads();
      test_sh();
      test_sw_split();
      test_split_loads();
      test_delayed_ack_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
